button_conditioner: RTL and testbench

Input conditioning stage for the SLC-3 top level: takes raw, asynchronous push-button levels from the board, synchronizes them into the `Clk` domain, debounces them with a per-button stability counter, and produces clean level and single-cycle press-pulse outputs. It sits directly upstream of `slc3`. Its `btn_level` outputs drive the `Run` and `Continue` inputs, replacing the bare synchronizer array in the top level.

---
 rtl/button_conditioner.sv | 89 ++++++++
 tb/tb_button_conditioner.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Push-button conditioner: per-bit synchronizer, stability-counter debounce, and press pulse.
// Optional press-pulse logic is built only when BTN_PRESS_PULSE_EN is defined; otherwise btn_press is tied low.
module button_conditioner #(
    parameter int N               = 2,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic [N-1:0] btn_in,
    output logic [N-1:0] btn_level,
    output logic [N-1:0] btn_press
);

    localparam int CW = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    // Stage 0 may go metastable; only the last stage feeds the debounce logic.
    logic [SYNC_STAGES-1:0][N-1:0] r_sync;
    logic [N-1:0]                  r_level;
    logic [CW-1:0]                 r_cnt [N];

    logic [N-1:0] w_sync_q;
    logic [N-1:0] w_differ;
    logic [N-1:0] w_expire;
    logic [N-1:0] w_accept;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], btn_in};
        end
    end

    assign w_sync_q = r_sync[SYNC_STAGES-1];
    assign w_differ = w_sync_q ^ r_level;

    always_comb begin
        w_expire = '0;
        for (int i = 0; i < N; i++) begin
            w_expire[i] = (r_cnt[i] == CNT_LAST);
        end
    end

    assign w_accept = w_differ & w_expire;

    // Any cycle where the synchronized value matches the accepted one restarts the window.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_level <= '0;
            for (int i = 0; i < N; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (!w_differ[i]) begin
                    r_cnt[i] <= '0;
                end else if (w_expire[i]) begin
                    r_level[i] <= w_sync_q[i];
                    r_cnt[i]   <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_ONE;
                end
            end
        end
    end

    assign btn_level = r_level;

`ifdef BTN_PRESS_PULSE_EN
    logic [N-1:0] r_press;

    // Registered alongside the level so the pulse coincides with the rising level.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_press <= '0;
        end else begin
            r_press <= w_accept & w_sync_q;
        end
    end

    assign btn_press = r_press;
`else
    assign btn_press = '0;
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner (N=2, SYNC_STAGES=2, DEBOUNCE_CYCLES=4) with an expected-value queue.
module tb_button_conditioner;

    localparam int N = 2;

`ifdef BTN_PRESS_PULSE_EN
    localparam logic [1:0] PRESS_MASK = 2'b11;
`else
    localparam logic [1:0] PRESS_MASK = 2'b00;
`endif

    logic       Clk;
    logic       Reset;
    logic [1:0] btn_in;
    logic [1:0] btn_level;
    logic [1:0] btn_press;

    int checks = 0;
    int errors = 0;

    logic [3:0] exp_q[$];

    button_conditioner #(
        .N(N),
        .SYNC_STAGES(2),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .btn_in(btn_in),
        .btn_level(btn_level),
        .btn_press(btn_press)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Pop one expected {level, press} entry and compare with the current outputs.
    task automatic compare(input string tag);
        logic [3:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s scoreboard empty", tag);
        end else begin
            e = exp_q.pop_front();
            checks++;
            assert (btn_level === e[3:2]) else begin
                errors++;
                $error("FAIL %s level got %b exp %b", tag, btn_level, e[3:2]);
            end
            checks++;
            assert (btn_press === e[1:0]) else begin
                errors++;
                $error("FAIL %s press got %b exp %b", tag, btn_press, e[1:0]);
            end
        end
    endtask

    // Expectation for the state right after the next rising edge.
    task automatic step(input string tag, input logic [1:0] lvl, input logic [1:0] prs);
        exp_q.push_back({lvl, prs & PRESS_MASK});
        @(posedge Clk);
        #1;
        compare(tag);
    endtask

    // Expectation for the current state, checked between edges.
    task automatic check_now(input string tag, input logic [1:0] lvl, input logic [1:0] prs);
        exp_q.push_back({lvl, prs & PRESS_MASK});
        #1;
        compare(tag);
    endtask

    // Six edges from input change to acceptance: five with the old level, then the new one.
    task automatic accept_run(input string tag, input logic [1:0] old_lvl,
                              input logic [1:0] new_lvl, input logic [1:0] prs);
        for (int k = 1; k <= 5; k++) step(tag, old_lvl, 2'b00);
        step(tag, new_lvl, prs);
        step(tag, new_lvl, 2'b00);
        step(tag, new_lvl, 2'b00);
    endtask

    logic [15:0] bounce_pat;
    logic [11:0] glitch_pat;

    initial begin
        Reset  = 1'b0;
        btn_in = 2'b00;
        #1 Reset = 1'b1;
        check_now("por", 2'b00, 2'b00);
        step("por_hold", 2'b00, 2'b00);
        step("por_hold", 2'b00, 2'b00);
        Reset = 1'b0;

        // Clean press then release on bit 0
        btn_in = 2'b01;
        accept_run("press0", 2'b00, 2'b01, 2'b01);
        btn_in = 2'b00;
        accept_run("release0", 2'b01, 2'b00, 2'b00);

        // Bounce: first run of four consecutive ones starts at cycle 9, accepted on edge 14
        bounce_pat = 16'b1111_1111_0111_0111;
        for (int k = 1; k <= 16; k++) begin
            btn_in = {1'b0, bounce_pat[k-1]};
            if (k < 14)       step("bounce", 2'b00, 2'b00);
            else if (k == 14) step("bounce", 2'b01, 2'b01);
            else              step("bounce", 2'b01, 2'b00);
        end

        // Bring bit 1 up while bit 0 stays high
        btn_in = 2'b11;
        accept_run("press1", 2'b01, 2'b11, 2'b10);

        // Two 3-cycle low glitches on bit 1 separated by one high cycle: neither accepted
        glitch_pat = 12'b1111_1000_1000;
        for (int k = 1; k <= 12; k++) begin
            btn_in = {glitch_pat[k-1], 1'b1};
            step("glitch1", 2'b11, 2'b00);
        end

        // Drop both, then reset in the middle of a bit-1 count
        btn_in = 2'b00;
        accept_run("release_all", 2'b11, 2'b00, 2'b00);
        btn_in = 2'b10;
        for (int k = 1; k <= 4; k++) step("midcount", 2'b00, 2'b00);
        Reset = 1'b1;
        check_now("midcount_rst", 2'b00, 2'b00);
        step("midcount_rst_hold", 2'b00, 2'b00);
        step("midcount_rst_hold", 2'b00, 2'b00);
        Reset = 1'b0;
        accept_run("after_rst1", 2'b00, 2'b10, 2'b10);

        // Reset with both levels high clears outputs immediately; both re-accepted together
        btn_in = 2'b11;
        accept_run("press_both", 2'b10, 2'b11, 2'b01);
        Reset = 1'b1;
        check_now("rst_async", 2'b00, 2'b00);
        step("rst_hold", 2'b00, 2'b00);
        step("rst_hold", 2'b00, 2'b00);
        Reset = 1'b0;
        accept_run("after_rst2", 2'b00, 2'b11, 2'b11);

        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL queue_drain left %0d exp 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
